bus_dma: RTL

// - Bus initiator for the data-memory/IO bus: copies a block of bytes src->dst over the same

---
 rtl/bus_dma_pkg.sv | 22 ++
 rtl/bus_dma.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus_dma initiator: default bus widths and FSM state encoding.
package bus_dma_pkg;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 8;
    localparam int DMA_LEN_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_FIN  = 3'd5
    } dma_state_t;

    // States in which the engine keeps its bus request raised.
    function automatic logic holds_bus(input dma_state_t st);
        return (st == ST_REQ) || (st == ST_RD) || (st == ST_CAP) || (st == ST_WR);
    endfunction

endpackage

// File: rtl/bus_dma.sv
// Block-copy bus initiator: reads bytes from src and writes them to dst over the shared CPU data bus.
// All outputs are registered from the next-state decode so the bus sees glitch-free strobes.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              src_inc,
    input  logic              dst_inc,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_w_en,
    output logic              bus_r_en,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    dma_state_t        state_r, state_s;
    logic [ADDR_W-1:0] cur_src_r, cur_src_s;
    logic [ADDR_W-1:0] cur_dst_r, cur_dst_s;
    logic [LEN_W-1:0]  remaining_r, remaining_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic              src_inc_r, src_inc_s;
    logic              dst_inc_r, dst_inc_s;
    logic              abort_pend_r, abort_pend_s;
    logic              aborted_r, aborted_s;

    logic              busy_r, done_r, bus_req_r, bus_w_en_r, bus_r_en_r;
    logic [ADDR_W-1:0] bus_addr_r, bus_addr_s;
    logic [DATA_W-1:0] bus_wdata_r, bus_wdata_s;

    // Next-state and datapath update decode for the transfer sequencer.
    always_comb begin
        state_s      = state_r;
        cur_src_s    = cur_src_r;
        cur_dst_s    = cur_dst_r;
        remaining_s  = remaining_r;
        data_s       = data_r;
        src_inc_s    = src_inc_r;
        dst_inc_s    = dst_inc_r;
        abort_pend_s = abort_pend_r;
        aborted_s    = aborted_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cur_src_s    = src;
                    cur_dst_s    = dst;
                    remaining_s  = len;
                    src_inc_s    = src_inc;
                    dst_inc_s    = dst_inc;
                    abort_pend_s = 1'b0;
                    aborted_s    = 1'b0;
                    if (len != LEN_ZERO) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    state_s   = ST_FIN;
                    aborted_s = 1'b1;
                end else if (bus_grant) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RD: begin
                // An abort seen mid-byte is remembered so the byte still gets written.
                abort_pend_s = abort_pend_r | abort;
                state_s      = ST_CAP;
            end
            ST_CAP: begin
                abort_pend_s = abort_pend_r | abort;
                data_s       = bus_rdata;
                state_s      = ST_WR;
            end
            ST_WR: begin
                remaining_s  = remaining_r - LEN_ONE;
                cur_src_s    = cur_src_r + {{(ADDR_W-1){1'b0}}, src_inc_r};
                cur_dst_s    = cur_dst_r + {{(ADDR_W-1){1'b0}}, dst_inc_r};
                abort_pend_s = 1'b0;
                if (remaining_r == LEN_ONE) begin
                    state_s = ST_FIN;
                end else if (abort || abort_pend_r) begin
                    state_s   = ST_FIN;
                    aborted_s = 1'b1;
                end else if (!bus_grant) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_FIN: begin
                abort_pend_s = 1'b0;
                state_s      = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus address/data selection for the upcoming state.
    always_comb begin
        bus_addr_s  = ADDR_ZERO;
        bus_wdata_s = DATA_ZERO;
        case (state_s)
            ST_RD, ST_CAP: begin
                bus_addr_s = cur_src_s;
            end
            ST_WR: begin
                bus_addr_s  = cur_dst_s;
                bus_wdata_s = data_s;
            end
            default: begin
                bus_addr_s  = ADDR_ZERO;
                bus_wdata_s = DATA_ZERO;
            end
        endcase
    end

    // Sequencer state, address/count registers and captured data byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cur_src_r    <= ADDR_ZERO;
            cur_dst_r    <= ADDR_ZERO;
            remaining_r  <= LEN_ZERO;
            data_r       <= DATA_ZERO;
            src_inc_r    <= 1'b0;
            dst_inc_r    <= 1'b0;
            abort_pend_r <= 1'b0;
            aborted_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cur_src_r    <= cur_src_s;
            cur_dst_r    <= cur_dst_s;
            remaining_r  <= remaining_s;
            data_r       <= data_s;
            src_inc_r    <= src_inc_s;
            dst_inc_r    <= dst_inc_s;
            abort_pend_r <= abort_pend_s;
            aborted_r    <= aborted_s;
        end
    end

    // Registered status and bus outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_r_en_r  <= 1'b0;
            bus_w_en_r  <= 1'b0;
            bus_addr_r  <= ADDR_ZERO;
            bus_wdata_r <= DATA_ZERO;
        end else begin
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
            bus_req_r   <= holds_bus(state_s);
            bus_r_en_r  <= (state_s == ST_RD) || (state_s == ST_CAP);
            bus_w_en_r  <= (state_s == ST_WR);
            bus_addr_r  <= bus_addr_s;
            bus_wdata_r <= bus_wdata_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign bus_req   = bus_req_r;
    assign bus_r_en  = bus_r_en_r;
    assign bus_w_en  = bus_w_en_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;

endmodule
